csi_rx_stream_ctrl: RTL and testbench
=====================================

# csi_rx_stream_ctrl

Frame-level sequencer for the CSI-2 receive path, in the D-PHY RX byte clock domain, between the D-PHY RX soft IP packet outputs and the byte-to-pixel converter. It tracks Frame Start/Frame End short packets and long-packet headers, and gates the byte-to-pixel stream to whole frames only. It checks each line's word count and the lines per frame against programmed values, detects stalled frames by timeout, and recovers by resetting the byte-to-pixel converter and re-arming on the next Frame Start.

## Interface
Parameters:
- TO_W, 20: width of the inactivity timeout counter; timeout fires at 2^TO_W − 1 idle cycles.
- RST_PULSE, 4: length in cycles of the byte-to-pixel reset pulse issued in RECOVER; legal range 1..15.

Ports:
- clk_byte_i  in  1  D-PHY RX byte clock (rx_clk_byte_fr); the block's only clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  level; capture frames while high.
- err_clr_i  in  1  one-cycle pulse; clears err_o.
- ref_dt_i  in  6  pixel data type to accept (RAW10 = 6'h2B).
- exp_wc_i  in  16  expected long-packet word count, in bytes.
- exp_lines_i  in  12  expected lines per frame.
- sp_en_i  in  1  short-packet header valid.
- lp_av_en_i  in  1  long-packet header valid, active video.
- dt_i  in  6  packet data type; valid with sp_en_i or lp_av_en_i.
- wc_i  in  16  packet word count; valid with lp_av_en_i.
- pass_o  out  1  gate ANDed onto byte-to-pixel lp_av_en and payload_en.
- b2p_rst_o  out  1  active-high reset request to the byte-to-pixel converter.
- frame_done_o  out  1  one-cycle pulse on each accepted Frame End.
- frame_cnt_o  out  16  completed-frame count; wraps.
- line_cnt_o  out  12  accepted lines in the current frame; saturates at 12'hFFF.
- err_o  out  3  sticky flags: [0] word-count mismatch, [1] line-count or framing error, [2] timeout.
- state_o  out  2  current state encoding.

## Operation
- States: IDLE = 0, WAIT_FS = 1, FRAME = 2, RECOVER = 3.
- IDLE:
  - pass_o = 0.
  - enable_i = 1 → WAIT_FS.
- WAIT_FS:
  - pass_o = 0.
  - sp_en_i with dt_i = 6'h00 (Frame Start) → FRAME; clear line_cnt_o to 0.
  - enable_i = 0 → IDLE.
  - All other packets are ignored.
- FRAME:
  - pass_o = 1.
  - lp_av_en_i with dt_i = ref_dt_i: increment line_cnt_o; if wc_i ≠ exp_wc_i, set err_o[0].
  - lp_av_en_i with any other dt_i: ignored, no count.
  - Frame End (sp_en_i, dt_i = 6'h01):
    - set err_o[1] if line_cnt_o ≠ exp_lines_i;
    - pulse frame_done_o;
    - frame_cnt_o +1, wrapping 16'hFFFF → 0;
    - next state WAIT_FS if enable_i = 1, else IDLE.
  - Frame Start while in FRAME (missing Frame End): set err_o[1] → RECOVER. frame_cnt_o does not increment.
  - Timeout counter reaches all-ones: set err_o[2] → RECOVER.
  - Line Start/Line End short packets (6'h02/6'h03) and other short packets are ignored.
  - Deasserting enable_i does not abort; the frame completes at Frame End.
- RECOVER:
  - pass_o = 0, b2p_rst_o = 1 for exactly RST_PULSE cycles.
  - Then → WAIT_FS if enable_i = 1, else IDLE.
  - Packets arriving during RECOVER are ignored.
- Timeout counter:
  - Width TO_W; counts only in FRAME.
  - Cleared on every sp_en_i or lp_av_en_i and on entry to FRAME.
  - Saturates at all-ones and does not wrap.
- Priority and collisions:
  - sp_en_i and lp_av_en_i in the same cycle: the short packet is processed; the long-packet header is dropped and not counted.
  - An error set and err_clr_i in the same cycle: set wins.
  - err_clr_i clears only err_o, not the counters.

## Timing
- All outputs are registered.
- A header on cycle N updates state_o, pass_o, line_cnt_o and err_o at N+1.
- frame_done_o is high for exactly cycle N+1 after Frame End.
- pass_o rises at N+1 after Frame Start. Payload of the first line arrives ≥ 2 byte clocks after its header, so no payload is lost.
- pass_o falls at N+1 after Frame End or after the error event.
- b2p_rst_o is high on cycles N+1 .. N+RST_PULSE after the error event. Exit from RECOVER occurs at N+RST_PULSE+1.
- The timeout fires 2^TO_W − 1 cycles after the last header seen in FRAME.
- Reset values: state_o = IDLE, pass_o = 0, b2p_rst_o = 0, frame_done_o = 0, frame_cnt_o = 0, line_cnt_o = 0, err_o = 0, timeout counter = 0.
- reset_i takes effect at the next edge from any state, including mid-frame and mid-RECOVER. A reset during RECOVER truncates the b2p_rst_o pulse.

## Test plan
- Nominal frame:
  - Setup: enable_i = 1, exp_wc_i = 640, exp_lines_i = 4.
  - Stimulus: Frame Start, then 4 × (lp_av_en_i, dt 2B, wc 640), then Frame End.
  - Required: pass_o high from the cycle after Frame Start through Frame End; frame_done_o single pulse; frame_cnt_o = 1; err_o = 0.
- Word-count error: one line with wc_i = 638 → err_o = 3'b001. The frame still completes and frame_cnt_o increments. err_clr_i → err_o = 0.
- Missing Frame End: Frame Start, 2 lines, Frame Start → err_o[1] = 1; b2p_rst_o high for exactly 4 cycles; state_o sequence 2 → 3 → 1; frame_cnt_o unchanged.
- Timeout: TO_W = 6; Frame Start followed by silence → err_o[2] set 63 cycles after Frame Start; RECOVER entered, then WAIT_FS.
- Disable mid-frame: drop enable_i after line 2; the frame completes to Frame End; state_o → IDLE; a subsequent Frame Start is ignored with pass_o = 0.
- Collisions and reset:
  - sp_en_i (Frame End) and lp_av_en_i in the same cycle → line not counted, err_o[1] set.
  - reset_i mid-FRAME → all outputs at reset values on the next cycle.
  - frame_cnt_o preloaded to 16'hFFFF by running frames → wraps to 0.

Source files
------------

// File: rtl/csi_rx_stream_ctrl.sv
// csi_rx_stream_ctrl
// Frame-level sequencer for the CSI-2 receive path (D-PHY RX byte clock).
// Watches Frame Start / Frame End short packets and active-video long-packet
// headers, opens the byte-to-pixel gate only for whole frames, checks the
// word count of each line and the number of lines per frame, and recovers
// from stalled or broken frames by pulsing a reset into the byte-to-pixel
// converter before re-arming on the next Frame Start.
module csi_rx_stream_ctrl #(
  parameter int TO_W      = 20,
  parameter int RST_PULSE = 4
) (
  input  logic        clk_byte_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        err_clr_i,
  input  logic [5:0]  ref_dt_i,
  input  logic [15:0] exp_wc_i,
  input  logic [11:0] exp_lines_i,
  input  logic        sp_en_i,
  input  logic        lp_av_en_i,
  input  logic [5:0]  dt_i,
  input  logic [15:0] wc_i,
  output logic        pass_o,
  output logic        b2p_rst_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o,
  output logic [11:0] line_cnt_o,
  output logic [2:0]  err_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_FS = 2'd1,
    S_FRAME   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam logic [5:0]      DT_FS    = 6'h00;
  localparam logic [5:0]      DT_FE    = 6'h01;
  localparam logic [11:0]     LINE_MAX = 12'hFFF;
  localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};
  // One below all-ones: the idle cycle on which the counter would reach
  // all-ones is the cycle the timeout fires.
  localparam logic [TO_W-1:0] TO_PRE   = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  // RECOVER lasts RST_PULSE cycles: load RST_PULSE-1 and leave at zero.
  localparam logic [3:0]      RST_LD   = 4'(RST_PULSE - 1);

  state_t          state_q,      state_d;
  logic            pass_q,       pass_d;
  logic            b2p_rst_q,    b2p_rst_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_cnt_q,  frame_cnt_d;
  logic [11:0]     line_cnt_q,   line_cnt_d;
  logic [2:0]      err_q,        err_d;
  logic [TO_W-1:0] to_cnt_q,     to_cnt_d;
  logic [3:0]      rst_cnt_q,    rst_cnt_d;

  logic       is_fs;
  logic       is_fe;
  logic       is_line;
  logic       any_hdr;
  logic [2:0] err_set;

  // Packet decode; a short packet always wins over a simultaneous long header.
  always_comb begin
    is_fs   = sp_en_i && (dt_i == DT_FS);
    is_fe   = sp_en_i && (dt_i == DT_FE);
    is_line = lp_av_en_i && !sp_en_i && (dt_i == ref_dt_i);
    any_hdr = sp_en_i || lp_av_en_i;
  end

  // Next-state, counter and error-flag logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    line_cnt_d   = line_cnt_q;
    to_cnt_d     = to_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    frame_done_d = 1'b0;
    err_set      = 3'b000;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_WAIT_FS;
        end
      end

      S_WAIT_FS: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (is_fs) begin
          state_d    = S_FRAME;
          line_cnt_d = 12'd0;
          to_cnt_d   = '0;
        end
      end

      S_FRAME: begin
        if (any_hdr) begin
          to_cnt_d = '0;
          if (is_fs) begin
            // Frame Start without a preceding Frame End: the frame is broken.
            err_set[1] = 1'b1;
            state_d    = S_RECOVER;
            rst_cnt_d  = RST_LD;
          end else if (is_fe) begin
            if (line_cnt_q != exp_lines_i) begin
              err_set[1] = 1'b1;
            end
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = enable_i ? S_WAIT_FS : S_IDLE;
          end else if (is_line) begin
            if (line_cnt_q != LINE_MAX) begin
              line_cnt_d = line_cnt_q + 12'd1;
            end
            if (wc_i != exp_wc_i) begin
              err_set[0] = 1'b1;
            end
          end
        end else if (to_cnt_q >= TO_PRE) begin
          // Counter reaches all-ones this cycle: the frame has stalled.
          to_cnt_d   = TO_MAX;
          err_set[2] = 1'b1;
          state_d    = S_RECOVER;
          rst_cnt_d  = RST_LD;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end

      S_RECOVER: begin
        if (rst_cnt_q == 4'd0) begin
          state_d = enable_i ? S_WAIT_FS : S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new error in the same cycle as a clear request survives the clear.
    err_d     = (err_clr_i ? 3'b000 : err_q) | err_set;
    pass_d    = (state_d == S_FRAME);
    b2p_rst_d = (state_d == S_RECOVER);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_byte_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      pass_q       <= 1'b0;
      b2p_rst_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
      line_cnt_q   <= 12'd0;
      err_q        <= 3'b000;
      to_cnt_q     <= '0;
      rst_cnt_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      b2p_rst_q    <= b2p_rst_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_cnt_q   <= line_cnt_d;
      err_q        <= err_d;
      to_cnt_q     <= to_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign pass_o       = pass_q;
  assign b2p_rst_o    = b2p_rst_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign line_cnt_o   = line_cnt_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_csi_rx_stream_ctrl.sv
// Testbench for csi_rx_stream_ctrl: scenario tasks plus randomized frames
// checked against a frame-level reference model (lines counted, word counts
// compared, frame count advanced) held in bench variables.
module tb_csi_rx_stream_ctrl;

  localparam int TO_W      = 6;
  localparam int RST_PULSE = 4;

  logic        clk_byte_i = 1'b0;
  logic        reset_i    = 1'b1;
  logic        enable_i   = 1'b0;
  logic        err_clr_i  = 1'b0;
  logic [5:0]  ref_dt_i   = 6'h2B;
  logic [15:0] exp_wc_i   = 16'd640;
  logic [11:0] exp_lines_i = 12'd4;
  logic        sp_en_i    = 1'b0;
  logic        lp_av_en_i = 1'b0;
  logic [5:0]  dt_i       = 6'h00;
  logic [15:0] wc_i       = 16'd0;
  logic        pass_o;
  logic        b2p_rst_o;
  logic        frame_done_o;
  logic [15:0] frame_cnt_o;
  logic [11:0] line_cnt_o;
  logic [2:0]  err_o;
  logic [1:0]  state_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_fcnt = 16'd0;

  csi_rx_stream_ctrl #(.TO_W(TO_W), .RST_PULSE(RST_PULSE)) dut (
    .clk_byte_i   (clk_byte_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .err_clr_i    (err_clr_i),
    .ref_dt_i     (ref_dt_i),
    .exp_wc_i     (exp_wc_i),
    .exp_lines_i  (exp_lines_i),
    .sp_en_i      (sp_en_i),
    .lp_av_en_i   (lp_av_en_i),
    .dt_i         (dt_i),
    .wc_i         (wc_i),
    .pass_o       (pass_o),
    .b2p_rst_o    (b2p_rst_o),
    .frame_done_o (frame_done_o),
    .frame_cnt_o  (frame_cnt_o),
    .line_cnt_o   (line_cnt_o),
    .err_o        (err_o),
    .state_o      (state_o)
  );

  always #5 clk_byte_i = ~clk_byte_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_byte_i);
    #1;
  endtask

  // Present one header for one cycle; on return the outputs show cycle N+1.
  task automatic pkt(input logic sp, input logic lp, input logic [5:0] dt, input logic [15:0] wc);
    sp_en_i    = sp;
    lp_av_en_i = lp;
    dt_i       = dt;
    wc_i       = wc;
    tick();
    sp_en_i    = 1'b0;
    lp_av_en_i = 1'b0;
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    n_chk++;
    if ({state_o, pass_o, b2p_rst_o, frame_done_o, frame_cnt_o, line_cnt_o, err_o} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_values act state=%0d pass=%0b rst=%0b done=%0b fcnt=%0d lcnt=%0d err=%b exp all zero",
               state_o, pass_o, b2p_rst_o, frame_done_o, frame_cnt_o, line_cnt_o, err_o);
    end
    m_fcnt = 16'd0;
  endtask

  task automatic test_nominal();
    int pass_low;
    enable_i = 1'b1; exp_wc_i = 16'd640; exp_lines_i = 12'd4; ref_dt_i = 6'h2B;
    tick();
    n_chk++;
    if (state_o !== 2'd1) begin n_fail++; $display("FAIL nominal_arm act=%0d exp=1", state_o); end
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    n_chk++;
    if (state_o !== 2'd2 || pass_o !== 1'b1 || line_cnt_o !== 12'd0) begin
      n_fail++; $display("FAIL nominal_fs act state=%0d pass=%0b lcnt=%0d exp 2/1/0", state_o, pass_o, line_cnt_o);
    end
    pass_low = 0;
    for (int i = 0; i < 4; i++) begin
      pkt(1'b0, 1'b1, 6'h2B, 16'd640);
      if (pass_o !== 1'b1) pass_low++;
      tick();
      if (pass_o !== 1'b1) pass_low++;
    end
    n_chk++;
    if (line_cnt_o !== 12'd4 || pass_low != 0) begin
      n_fail++; $display("FAIL nominal_lines act lcnt=%0d pass_low=%0d exp 4/0", line_cnt_o, pass_low);
    end
    pkt(1'b1, 1'b0, 6'h01, 16'd0);
    m_fcnt++;
    n_chk++;
    if (frame_done_o !== 1'b1 || frame_cnt_o !== m_fcnt || err_o !== 3'b000 || pass_o !== 1'b0 || state_o !== 2'd1) begin
      n_fail++; $display("FAIL nominal_fe act done=%0b fcnt=%0d err=%b pass=%0b state=%0d exp 1/%0d/000/0/1",
                         frame_done_o, frame_cnt_o, err_o, pass_o, state_o, m_fcnt);
    end
    tick();
    n_chk++;
    if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL nominal_done_pulse act=%0b exp=0", frame_done_o); end
  endtask

  task automatic test_wc_error();
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    for (int i = 0; i < 4; i++) pkt(1'b0, 1'b1, 6'h2B, (i == 2) ? 16'd638 : 16'd640);
    n_chk++;
    if (err_o !== 3'b001) begin n_fail++; $display("FAIL wc_err_flag act=%b exp=001", err_o); end
    pkt(1'b1, 1'b0, 6'h01, 16'd0);
    m_fcnt++;
    n_chk++;
    if (frame_cnt_o !== m_fcnt || err_o !== 3'b001 || frame_done_o !== 1'b1) begin
      n_fail++; $display("FAIL wc_err_fe act fcnt=%0d err=%b done=%0b exp %0d/001/1", frame_cnt_o, err_o, frame_done_o, m_fcnt);
    end
    clear_err();
    n_chk++;
    if (err_o !== 3'b000 || frame_cnt_o !== m_fcnt) begin
      n_fail++; $display("FAIL wc_err_clear act err=%b fcnt=%0d exp 000/%0d", err_o, frame_cnt_o, m_fcnt);
    end
  endtask

  task automatic test_missing_fe();
    int rst_hi;
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    n_chk++;
    if (state_o !== 2'd2) begin n_fail++; $display("FAIL mfe_frame act=%0d exp=2", state_o); end
    pkt(1'b0, 1'b1, 6'h2B, 16'd640);
    pkt(1'b0, 1'b1, 6'h2B, 16'd640);
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    n_chk++;
    if (state_o !== 2'd3 || err_o !== 3'b010 || pass_o !== 1'b0) begin
      n_fail++; $display("FAIL mfe_recover act state=%0d err=%b pass=%0b exp 3/010/0", state_o, err_o, pass_o);
    end
    rst_hi = b2p_rst_o ? 1 : 0;
    // a Frame Start during RECOVER must be ignored
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    if (b2p_rst_o) rst_hi++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b2p_rst_o) rst_hi++;
    end
    n_chk++;
    if (rst_hi != RST_PULSE || state_o !== 2'd1 || frame_cnt_o !== m_fcnt) begin
      n_fail++; $display("FAIL mfe_pulse act rst_cycles=%0d state=%0d fcnt=%0d exp %0d/1/%0d",
                         rst_hi, state_o, frame_cnt_o, RST_PULSE, m_fcnt);
    end
    clear_err();
  endtask

  task automatic test_timeout();
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    for (int i = 0; i < 62; i++) tick();
    n_chk++;
    if (state_o !== 2'd2 || err_o !== 3'b000) begin
      n_fail++; $display("FAIL timeout_early act state=%0d err=%b exp 2/000", state_o, err_o);
    end
    tick();
    n_chk++;
    if (state_o !== 2'd3 || err_o !== 3'b100 || b2p_rst_o !== 1'b1) begin
      n_fail++; $display("FAIL timeout_fire act state=%0d err=%b rst=%0b exp 3/100/1", state_o, err_o, b2p_rst_o);
    end
    for (int i = 0; i < RST_PULSE; i++) tick();
    n_chk++;
    if (state_o !== 2'd1 || b2p_rst_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_exit act state=%0d rst=%0b exp 1/0", state_o, b2p_rst_o);
    end
    clear_err();
  endtask

  task automatic test_disable();
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    pkt(1'b0, 1'b1, 6'h2B, 16'd640);
    pkt(1'b0, 1'b1, 6'h2B, 16'd640);
    enable_i = 1'b0;
    pkt(1'b0, 1'b1, 6'h2B, 16'd640);
    n_chk++;
    if (state_o !== 2'd2 || pass_o !== 1'b1) begin
      n_fail++; $display("FAIL disable_hold act state=%0d pass=%0b exp 2/1", state_o, pass_o);
    end
    pkt(1'b0, 1'b1, 6'h2B, 16'd640);
    pkt(1'b1, 1'b0, 6'h01, 16'd0);
    m_fcnt++;
    n_chk++;
    if (state_o !== 2'd0 || frame_done_o !== 1'b1 || frame_cnt_o !== m_fcnt || err_o !== 3'b000) begin
      n_fail++; $display("FAIL disable_fe act state=%0d done=%0b fcnt=%0d err=%b exp 0/1/%0d/000",
                         state_o, frame_done_o, frame_cnt_o, err_o, m_fcnt);
    end
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    tick();
    n_chk++;
    if (state_o !== 2'd0 || pass_o !== 1'b0) begin
      n_fail++; $display("FAIL disable_ignore_fs act state=%0d pass=%0b exp 0/0", state_o, pass_o);
    end
    enable_i = 1'b1;
    tick();
  endtask

  task automatic test_collision();
    // ref type equals the Frame End code so a dropped header is observable
    ref_dt_i = 6'h01;
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    for (int i = 0; i < 3; i++) pkt(1'b0, 1'b1, 6'h01, 16'd640);
    pkt(1'b1, 1'b1, 6'h01, 16'd640);
    m_fcnt++;
    n_chk++;
    if (line_cnt_o !== 12'd3 || err_o !== 3'b010 || frame_cnt_o !== m_fcnt) begin
      n_fail++; $display("FAIL collision_sp_lp act lcnt=%0d err=%b fcnt=%0d exp 3/010/%0d",
                         line_cnt_o, err_o, frame_cnt_o, m_fcnt);
    end
    ref_dt_i = 6'h2B;
    clear_err();
    // error set and clear in the same cycle: the set wins
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    err_clr_i = 1'b1;
    pkt(1'b0, 1'b1, 6'h2B, 16'd1);
    err_clr_i = 1'b0;
    n_chk++;
    if (err_o !== 3'b001 || frame_cnt_o !== m_fcnt || line_cnt_o !== 12'd1) begin
      n_fail++; $display("FAIL collision_set_clr act err=%b fcnt=%0d lcnt=%0d exp 001/%0d/1",
                         err_o, frame_cnt_o, line_cnt_o, m_fcnt);
    end
    for (int i = 0; i < 3; i++) pkt(1'b0, 1'b1, 6'h2B, 16'd640);
    pkt(1'b1, 1'b0, 6'h01, 16'd0);
    m_fcnt++;
    clear_err();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 12; f++) begin
      int lines;
      int npk;
      logic [2:0]  e;
      logic [15:0] wc;
      exp_lines_i = 12'($urandom_range(1, 6));
      exp_wc_i    = 16'($urandom);
      lines = 0;
      e = 3'b000;
      pkt(1'b1, 1'b0, 6'h00, 16'd0);
      npk = $urandom_range(2, 10);
      for (int p = 0; p < npk; p++) begin
        case ($urandom_range(0, 5))
          0, 1, 2: begin
            wc = exp_wc_i;
            if ($urandom_range(0, 5) == 0) begin
              wc = exp_wc_i ^ 16'(1 << $urandom_range(0, 15));
              e[0] = 1'b1;
            end
            pkt(1'b0, 1'b1, 6'h2B, wc);
            lines++;
          end
          3: pkt(1'b0, 1'b1, 6'h2A, exp_wc_i);
          4: pkt(1'b1, 1'b0, ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 16'd0);
          default: begin
            for (int g = 0; g < int'($urandom_range(1, 8)); g++) tick();
          end
        endcase
        n_chk++;
        if (line_cnt_o !== 12'(lines) || state_o !== 2'd2 || err_o !== e) begin
          n_fail++; $display("FAIL rand_line f=%0d p=%0d act lcnt=%0d state=%0d err=%b exp %0d/2/%b",
                             f, p, line_cnt_o, state_o, err_o, lines, e);
        end
      end
      pkt(1'b1, 1'b0, 6'h01, 16'd0);
      if (lines != int'(exp_lines_i)) e[1] = 1'b1;
      m_fcnt++;
      n_chk++;
      if (frame_done_o !== 1'b1 || frame_cnt_o !== m_fcnt || err_o !== e || state_o !== 2'd1) begin
        n_fail++; $display("FAIL rand_fe f=%0d act done=%0b fcnt=%0d err=%b state=%0d exp 1/%0d/%b/1",
                           f, frame_done_o, frame_cnt_o, err_o, state_o, m_fcnt, e);
      end
      clear_err();
    end
  endtask

  task automatic test_reset_mid();
    exp_wc_i = 16'd640; exp_lines_i = 12'd4;
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    pkt(1'b0, 1'b1, 6'h2B, 16'd5);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    m_fcnt = 16'd0;
    n_chk++;
    if ({state_o, pass_o, b2p_rst_o, frame_done_o, frame_cnt_o, line_cnt_o, err_o} !== 36'd0) begin
      n_fail++; $display("FAIL reset_mid_frame act state=%0d pass=%0b lcnt=%0d err=%b fcnt=%0d exp all zero",
                         state_o, pass_o, line_cnt_o, err_o, frame_cnt_o);
    end
    tick();
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    pkt(1'b1, 1'b0, 6'h00, 16'd0);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_chk++;
    if (b2p_rst_o !== 1'b0 || state_o !== 2'd0 || err_o !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_recover act rst=%0d state=%0d err=%b exp 0/0/000", b2p_rst_o, state_o, err_o);
    end
  endtask

  task automatic test_wrap();
    exp_lines_i = 12'd0;
    tick();
    force dut.frame_cnt_q = 16'hFFFE;
    tick();
    release dut.frame_cnt_q;
    m_fcnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      pkt(1'b1, 1'b0, 6'h00, 16'd0);
      pkt(1'b1, 1'b0, 6'h01, 16'd0);
      m_fcnt++;
      n_chk++;
      if (frame_cnt_o !== m_fcnt || err_o !== 3'b000) begin
        n_fail++; $display("FAIL wrap_%0d act fcnt=%h err=%b exp %h/000", k, frame_cnt_o, err_o, m_fcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wc_error();
    test_missing_fe();
    test_timeout();
    test_disable();
    test_collision();
    test_random_frames();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
